data_sram_arbiter: RTL
======================

# data_sram_arbiter

Two-port arbiter that shares the single-port synchronous data SRAM between the pipeline's memory access path (port 0, driven from the EXE/MEM stages) and a secondary requester (port 1, debug/DMA loader). Each port uses a req/addr_ok/data_ok handshake. Port 0 has fixed priority, with a starvation counter that guarantees port 1 forward progress. The block sits between the pipeline data port and the SRAM macro and owns all SRAM enable/strobe sequencing.

## Interface
- STARVE_LIMIT, 3: consecutive cycles port 1 may be refused while requesting before it is forced to win; legal range 1–15.
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- m0_req  in  1  port 0 request valid
- m0_wr  in  1  1 = write, 0 = read
- m0_wstrb  in  4  byte write strobes, ignored on reads
- m0_addr  in  32  byte address, passed through unmodified
- m0_wdata  in  32  write data
- m0_addr_ok  out  1  port 0 request accepted this cycle
- m0_data_ok  out  1  port 0 response pulse (read data valid / write done)
- m0_rdata  out  32  read data, qualified by m0_data_ok
- m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok, m1_rdata: same widths and meanings for port 1
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after sram_en

## Operation
- Grant, combinational each cycle: resetn low → no grant; m1_req && (wait_cnt == STARVE_LIMIT) → port 1; else m0_req → port 0; else m1_req → port 1; else none.
- mN_addr_ok = grant to port N. At most one addr_ok high per cycle. A handshake occurs when req && addr_ok.
- SRAM drive on a handshake: sram_en = 1; sram_we = wstrb if wr, else 4'h0; sram_addr/sram_wdata = granted port's fields. With no grant: sram_en = 0, sram_we = 0, addr/wdata = port 0 fields (don't care).
- wait_cnt (4 bits): resets to 0; when m1_req && !m1_addr_ok, increment, saturating at STARVE_LIMIT; otherwise clear to 0.
- Response register: on a handshake, resp_valid ← 1 and resp_id ← granted port; otherwise resp_valid ← 0.
- m0_data_ok = resp_valid && resp_id == 0; m1_data_ok = resp_valid && resp_id == 1. Reads and writes both produce exactly one data_ok.
- m0_rdata = m1_rdata = sram_rdata. Only the port with data_ok may sample it.
- Write with wstrb = 4'h0: accepted; sram_en = 1, sram_we = 0; data_ok returned normally.
- No response backpressure: requesters must accept data_ok in the cycle it pulses.
- Requesters hold req and all fields stable until addr_ok. Changing them earlier is illegal and is not checked.

## Timing
- Reset values (resetn low at an edge): resp_valid = 0, resp_id = 0, wait_cnt = 0. While resetn is low, all addr_ok, data_ok, sram_en and sram_we are 0.
- Handshake in cycle N → SRAM access in cycle N (same-cycle drive) → mN_data_ok and rdata in cycle N+1.
- Throughput is one access per cycle. Back-to-back handshakes from either port produce back-to-back data_ok in handshake order.
- Reset asserted in the cycle after a handshake: the pending data_ok is suppressed and never delivered.
- Simultaneous requests with wait_cnt < STARVE_LIMIT: port 0 wins and port 1 waits. With wait_cnt == STARVE_LIMIT: port 1 wins, port 0 waits one cycle, and wait_cnt clears.
- Port 1 withdrawing req clears wait_cnt. This is illegal per the handshake rule but still defined.

## Test plan
- Single read, port 0: SRAM word 0x100 = 0xDEADBEEF, m0 read 0x100 → m0_addr_ok in cycle N, sram_en = 1, sram_we = 0 in N; m0_data_ok = 1 with rdata 0xDEADBEEF in N+1; m1_data_ok stays 0.
- Byte write, port 1: m1 write addr 0x200, wstrb 4'b0010, wdata 0x0000AB00 → sram_we = 4'b0010 in N; m1_data_ok in N+1; a later read of 0x200 returns the old word with byte 1 = 0xAB.
- Starvation (STARVE_LIMIT = 3): m0 and m1 both request continuously from cycle 0 → m0 granted cycles 0–2, m1 granted cycle 3, m0 cycles 4–6, m1 cycle 7; data_ok follows each grant one cycle later.
- Back-to-back mixed stream: m0 read A, m0 write B, m1 read C in cycles 0–2 → data_ok pulses in cycles 1, 2, 3 with matching ids; read C returns the data written at B if C == B.
- Reset mid-operation: m0 handshake in cycle 5, resetn low in cycle 6 → no m0_data_ok in cycle 6; all outputs 0; wait_cnt = 0 after release.
- Zero-strobe write: m0 write, wstrb 0 → sram_en = 1, sram_we = 0, memory unchanged, m0_data_ok next cycle.

Source files
------------

// File: rtl/data_sram_arbiter_if.sv
// rtl/data_sram_arbiter_if.sv - requester and SRAM signal bundle for the data SRAM arbiter
interface data_sram_arbiter_if;
    logic        m0_req;
    logic        m0_wr;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_addr_ok;
    logic        m0_data_ok;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_wr;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_addr_ok;
    logic        m1_data_ok;
    logic [31:0] m1_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // Arbiter side: consumes requests and SRAM read data, drives handshakes and SRAM controls
    modport slave (
        input  m0_req, m0_wr, m0_wstrb, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata,
        input  sram_rdata,
        output m0_addr_ok, m0_data_ok, m0_rdata,
        output m1_addr_ok, m1_data_ok, m1_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    // Environment side: requesters plus the SRAM macro
    modport master (
        output m0_req, m0_wr, m0_wstrb, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata,
        output sram_rdata,
        input  m0_addr_ok, m0_data_ok, m0_rdata,
        input  m1_addr_ok, m1_data_ok, m1_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/data_sram_arbiter.sv
// rtl/data_sram_arbiter.sv - fixed-priority two-port arbiter for the single-port data SRAM
module data_sram_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_M0   = 2'd1,
        GRANT_M1   = 2'd2
    } grant_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    grant_t     grant;
    logic [3:0] wait_cnt;
    logic       resp_valid;
    logic       resp_id;

    // Port 0 wins by default; port 1 is forced through once it has been refused LIMIT times
    always_comb begin
        grant = GRANT_NONE;
        if (!resetn) begin
            grant = GRANT_NONE;
        end else if (bus.m1_req && (wait_cnt == LIMIT)) begin
            grant = GRANT_M1;
        end else if (bus.m0_req) begin
            grant = GRANT_M0;
        end else if (bus.m1_req) begin
            grant = GRANT_M1;
        end
    end

    // Handshake acknowledges and same-cycle SRAM drive from the granted port
    always_comb begin
        bus.m0_addr_ok = 1'b0;
        bus.m1_addr_ok = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = 4'h0;
        bus.sram_addr  = bus.m0_addr;
        bus.sram_wdata = bus.m0_wdata;
        case (grant)
            GRANT_M0: begin
                bus.m0_addr_ok = 1'b1;
                bus.sram_en    = 1'b1;
                bus.sram_we    = bus.m0_wr ? bus.m0_wstrb : 4'h0;
                bus.sram_addr  = bus.m0_addr;
                bus.sram_wdata = bus.m0_wdata;
            end
            GRANT_M1: begin
                bus.m1_addr_ok = 1'b1;
                bus.sram_en    = 1'b1;
                bus.sram_we    = bus.m1_wr ? bus.m1_wstrb : 4'h0;
                bus.sram_addr  = bus.m1_addr;
                bus.sram_wdata = bus.m1_wdata;
            end
            default: begin
            end
        endcase
    end

    // Count consecutive refused port-1 cycles; any grant or withdrawn request clears it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= 4'd0;
        end else if (bus.m1_req && !bus.m1_addr_ok) begin
            if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Remember which port owns the SRAM response returning next cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
        end else if (grant != GRANT_NONE) begin
            resp_valid <= 1'b1;
            resp_id    <= (grant == GRANT_M1);
        end else begin
            resp_valid <= 1'b0;
        end
    end

    // Gating with resetn drops a response pending across a reset assertion
    assign bus.m0_data_ok = resetn && resp_valid && !resp_id;
    assign bus.m1_data_ok = resetn && resp_valid && resp_id;
    assign bus.m0_rdata   = bus.sram_rdata;
    assign bus.m1_rdata   = bus.sram_rdata;

endmodule
